// File: rtl/sad_diff_accumulator_if.sv
// sad_diff_accumulator_if
// Groups the sample-input and result-output handshakes of sad_diff_accumulator.
//   in_valid/in_ready/a/b : sample pair stream (source -> engine)
//   thresh                : compare threshold for the window total
//   out_valid/out_ready   : window result handshake (engine -> consumer)
//   sad/below             : window total and (sad <= thresh) flag
//   busy                  : engine is out of its post-reset idle state
// Modports: master = sample source / result consumer, slave = the engine.
interface sad_diff_accumulator_if #(
    parameter int unsigned ACC_W = 11
) ();
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [ACC_W-1:0] thresh;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] sad;
    logic             below;
    logic             busy;

    modport master (
        output in_valid, a, b, thresh, out_ready,
        input  in_ready, out_valid, sad, below, busy
    );

    modport slave (
        input  in_valid, a, b, thresh, out_ready,
        output in_ready, out_valid, sad, below, busy
    );
endinterface

// File: rtl/sad_diff_accumulator.sv
// sad_diff_accumulator
// Streaming sum-of-absolute-differences engine. Each accepted pair (a, b) yields
// |a - b| in a registered subtract/negate stage; a second stage accumulates a
// window of N_SAMPLES values and presents the total with a threshold flag.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : sad_diff_accumulator_if.slave (pair input, threshold, result output, busy)
// Parameters:
//   N_SAMPLES : pairs per window (1..255)
//   ACC_W     : accumulator / result width (8..16)
// Build option:
//   SAD_SATURATE_EN : when defined the accumulator saturates at 2^ACC_W-1
//                     instead of wrapping.
module sad_diff_accumulator #(
    parameter int unsigned N_SAMPLES = 8,
    parameter int unsigned ACC_W     = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sad_diff_accumulator_if.slave   bus
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       d_q;
    logic             s1_valid_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             below_q, below_d;

    logic             in_ready;
    logic             accept;
    logic [8:0]       diff9;
    logic [7:0]       abs_diff;
    logic [ACC_W-1:0] acc_sum;

    assign in_ready = (state_q == StAccum);
    assign accept   = bus.in_valid && in_ready;

    // a - b as a + ~b + 1 in 9 bits; bit 8 set means a < b (borrow).
    assign diff9    = {1'b0, bus.a} + {1'b1, ~bus.b} + 9'd1;
    assign abs_diff = diff9[8] ? (~diff9[7:0] + 8'd1) : diff9[7:0];

`ifdef SAD_SATURATE_EN
    logic [ACC_W:0] acc_wide;
    always_comb begin
        acc_wide = {1'b0, acc_q} + (ACC_W + 1)'(d_q);
        // Carry-out clamps to all ones; a clamped value plus d stays clamped.
        acc_sum  = acc_wide[ACC_W] ? '1 : acc_wide[ACC_W-1:0];
    end
`else
    always_comb begin
        acc_sum = acc_q + ACC_W'(d_q);
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        below_d = below_q;

        if (s1_valid_q) begin
            acc_d = acc_sum;
        end

        unique case (state_q)
            StIdle: begin
                state_d = StAccum;
            end
            StAccum: begin
                if (accept) begin
                    if (cnt_q == 8'(N_SAMPLES - 1)) begin
                        cnt_d   = 8'd0;
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StDrain: begin
                // acc_d already includes the last stage-1 value here.
                below_d = (acc_d <= bus.thresh);
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    below_d = 1'b0;
                    state_d = StAccum;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            d_q        <= 8'd0;
            s1_valid_q <= 1'b0;
            acc_q      <= '0;
            below_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= accept;
            acc_q      <= acc_d;
            below_q    <= below_d;
            if (accept) begin
                d_q <= abs_diff;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == StDone);
    assign bus.sad       = acc_q;
    assign bus.below     = below_q;
    assign bus.busy      = (state_q != StIdle);

endmodule
